// File: rtl/vga_capture.sv
// Single-frame VGA capture. It recovers the raster position from the HS/VS
// syncs and writes each active pixel of one frame to a framebuffer port.
module vga_capture #(
  parameter int H_ACTIVE = 640,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int AW       = 19
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          pix_ce_i,
  input  logic          start_i,
  input  logic [11:0]   vga_rgb_i,
  input  logic          vga_hs_i,
  input  logic          vga_vs_i,
  output logic          wr_en_o,
  output logic [AW-1:0] wr_addr_o,
  output logic [11:0]   wr_data_o,
  output logic          busy_o,
  output logic          capture_done_o,
  output logic          sync_err_o
);

  localparam int HCW = $clog2(H_SYNC + H_BP + H_ACTIVE) + 2;
  localparam int VCW = $clog2(V_SYNC + V_BP + V_ACTIVE) + 2;
  localparam logic [HCW-1:0] H_START  = HCW'(H_SYNC + H_BP);
  localparam logic [HCW-1:0] H_END    = HCW'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [VCW-1:0] V_START  = VCW'(V_SYNC + V_BP);
  localparam logic [VCW-1:0] V_END    = VCW'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [AW-1:0]  LAST_IDX = AW'(H_ACTIVE * V_ACTIVE - 1);

  typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE, DONE} state_t;

  state_t          r_state, w_nextState;
  logic            r_hsQ, r_vsQ;
  logic [HCW-1:0]  r_hCnt, w_hNext;
  logic [VCW-1:0]  r_vCnt, w_vNext;
  logic [AW-1:0]   r_pixIdx;
  logic            r_wrEn;
  logic [AW-1:0]   r_wrAddr;
  logic [11:0]     r_wrData;
  logic            r_syncErr;
  logic            w_hsFall, w_vsFall, w_active, w_lineCut;
  logic            w_syncErr, w_write, w_lastWrite, w_startAccept;

  // Counters are judged by their post-tick value, so the HS-falling tick is h=0.
  always_comb begin
    w_hsFall = pix_ce_i & r_hsQ & ~vga_hs_i;
    w_vsFall = pix_ce_i & r_vsQ & ~vga_vs_i;
    w_hNext  = r_hCnt;
    if (w_hsFall)
      w_hNext = '0;
    else if (r_hCnt != '1)
      w_hNext = r_hCnt + HCW'(1);
    w_vNext = r_vCnt;
    if (w_vsFall)
      w_vNext = '0;
    else if (w_hsFall)
      w_vNext = r_vCnt + VCW'(1);
    w_active = (w_hNext >= H_START) && (w_hNext < H_END) &&
               (w_vNext >= V_START) && (w_vNext < V_END);
    w_lineCut     = w_hsFall && (r_hCnt >= H_START) && (r_hCnt < H_END);
    w_syncErr     = (r_state == CAPTURE) && (w_lineCut || w_vsFall);
    w_write       = pix_ce_i && (r_state == CAPTURE) && !w_syncErr && w_active;
    w_lastWrite   = w_write && (r_pixIdx == LAST_IDX);
    w_startAccept = (r_state == IDLE) && start_i;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_startAccept) w_nextState = WAIT_VS;
      WAIT_VS: if (w_vsFall) w_nextState = CAPTURE;
      CAPTURE: begin
        if (w_syncErr)
          w_nextState = WAIT_VS;
        else if (w_lastWrite)
          w_nextState = DONE;
      end
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i)
      r_state <= IDLE;
    else
      r_state <= w_nextState;
  end

  // A sync error drops the partial frame; the next clean VS re-arms from pixel 0.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_hsQ     <= 1'b1;
      r_vsQ     <= 1'b1;
      r_hCnt    <= '0;
      r_vCnt    <= '0;
      r_pixIdx  <= '0;
      r_wrEn    <= 1'b0;
      r_wrAddr  <= '0;
      r_wrData  <= '0;
      r_syncErr <= 1'b0;
    end else begin
      r_wrEn <= w_write;
      if (pix_ce_i) begin
        r_hsQ  <= vga_hs_i;
        r_vsQ  <= vga_vs_i;
        r_hCnt <= w_hNext;
        r_vCnt <= w_vNext;
      end
      if (w_write) begin
        r_wrAddr <= r_pixIdx;
        r_wrData <= vga_rgb_i;
        r_pixIdx <= w_lastWrite ? '0 : r_pixIdx + AW'(1);
      end
      if (w_syncErr) begin
        r_syncErr <= 1'b1;
        r_pixIdx  <= '0;
      end
      if (w_startAccept) begin
        r_syncErr <= 1'b0;
        r_pixIdx  <= '0;
      end
    end
  end

  assign wr_en_o        = r_wrEn;
  assign wr_addr_o      = r_wrAddr;
  assign wr_data_o      = r_wrData;
  assign busy_o         = (r_state == WAIT_VS) || (r_state == CAPTURE);
  assign capture_done_o = (r_state == DONE);
  assign sync_err_o     = r_syncErr;

endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture: a model raster source (8x4 active, 14 ticks x 7 lines)
// drives scenarios in sequence while a monitor logs every framebuffer write.
module tb_vga_capture;

  localparam int H_ACTIVE    = 8;
  localparam int H_SYNC      = 2;
  localparam int H_BP        = 2;
  localparam int V_ACTIVE    = 4;
  localparam int V_SYNC      = 1;
  localparam int V_BP        = 1;
  localparam int AW          = 5;
  localparam int LINE_TICKS  = 14;
  localparam int N_LINES     = 7;
  localparam int FRAME_TICKS = LINE_TICKS * N_LINES;

  logic          clk_i = 1'b0;
  logic          rstn_i;
  logic          pix_ce_i;
  logic          start_i;
  logic [11:0]   vga_rgb_i;
  logic          vga_hs_i;
  logic          vga_vs_i;
  logic          wr_en_o;
  logic [AW-1:0] wr_addr_o;
  logic [11:0]   wr_data_o;
  logic          busy_o;
  logic          capture_done_o;
  logic          sync_err_o;

  always #5 clk_i = ~clk_i;

  vga_capture #(
    .H_ACTIVE(H_ACTIVE), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_SYNC(V_SYNC), .V_BP(V_BP), .AW(AW)
  ) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .pix_ce_i(pix_ce_i), .start_i(start_i),
    .vga_rgb_i(vga_rgb_i), .vga_hs_i(vga_hs_i), .vga_vs_i(vga_vs_i),
    .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
    .busy_o(busy_o), .capture_done_o(capture_done_o), .sync_err_o(sync_err_o)
  );

  int            nCompared = 0;
  int            nMismatch = 0;
  int            lineIdx = 6;
  int            tickIdx = 0;
  int            cutLine = -1;
  logic          armAfterDone = 1'b0;
  logic [AW-1:0] wrAddrLog[$];
  logic [11:0]   wrDataLog[$];
  int            doneCount = 0;

  always @(negedge clk_i) begin
    if (wr_en_o === 1'b1) begin
      wrAddrLog.push_back(wr_addr_o);
      wrDataLog.push_back(wr_data_o);
    end
    if (capture_done_o === 1'b1)
      doneCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatch++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One pixel tick every 4 clocks; optionally re-arms one clock after capture_done_o.
  task automatic applyStimulus(input int nTicks);
    logic reArm;
    for (int n = 0; n < nTicks; n++) begin
      if (lineIdx == cutLine && tickIdx == 9) begin
        lineIdx = lineIdx + 1;
        tickIdx = 0;
        cutLine = -1;
      end
      @(posedge clk_i); #1;
      pix_ce_i = 1'b1;
      vga_hs_i = (tickIdx < 2) ? 1'b0 : 1'b1;
      vga_vs_i = (lineIdx == 0) ? 1'b0 : 1'b1;
      if (lineIdx >= 2 && lineIdx < 6 && tickIdx >= 4 && tickIdx < 12)
        vga_rgb_i = 12'((lineIdx - 2) * 8 + (tickIdx - 4));
      else
        vga_rgb_i = 12'hABC;
      @(posedge clk_i); #1;
      pix_ce_i = 1'b0;
      reArm = armAfterDone && (capture_done_o === 1'b1);
      if (reArm) armAfterDone = 1'b0;
      @(posedge clk_i); #1;
      if (reArm) start_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      tickIdx = tickIdx + 1;
      if (tickIdx == LINE_TICKS) begin
        tickIdx = 0;
        lineIdx = (lineIdx + 1) % N_LINES;
      end
    end
  endtask

  task automatic runToFrameStart();
    int guard;
    guard = 0;
    applyStimulus(1);
    while (!(lineIdx == 0 && tickIdx == 0) && guard < 200) begin
      applyStimulus(1);
      guard++;
    end
  endtask

  task automatic startPulse();
    @(posedge clk_i); #1;
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
  endtask

  task automatic checkFrame(input string tag, input int base);
    for (int i = 0; i < 32; i++) begin
      if (base + i < wrAddrLog.size()) begin
        checkOutput({tag, "_addr"}, 32'(wrAddrLog[base + i]), 32'(i));
        checkOutput({tag, "_data"}, 32'(wrDataLog[base + i]), 32'(i));
      end
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_wr_en"}, 32'(wr_en_o), 0);
    checkOutput({tag, "_wr_addr"}, 32'(wr_addr_o), 0);
    checkOutput({tag, "_wr_data"}, 32'(wr_data_o), 0);
    checkOutput({tag, "_busy"}, 32'(busy_o), 0);
    checkOutput({tag, "_done"}, 32'(capture_done_o), 0);
    checkOutput({tag, "_sync_err"}, 32'(sync_err_o), 0);
  endtask

  initial begin
    int base;
    int d0;
    int guard;
    rstn_i    = 1'b0;
    pix_ce_i  = 1'b0;
    start_i   = 1'b0;
    vga_hs_i  = 1'b1;
    vga_vs_i  = 1'b1;
    vga_rgb_i = 12'h000;
    repeat (3) @(posedge clk_i);
    #1 rstn_i = 1'b1;
    checkAllZero("reset");

    $display("[TB] nominal frame");
    startPulse();
    checkOutput("nominal_busy_armed", 32'(busy_o), 1);
    base = wrAddrLog.size();
    d0   = doneCount;
    applyStimulus(LINE_TICKS + FRAME_TICKS);
    checkOutput("nominal_count", 32'(wrAddrLog.size() - base), 32);
    checkFrame("nominal", base);
    checkOutput("nominal_done", 32'(doneCount - d0), 1);
    checkOutput("nominal_busy_after", 32'(busy_o), 0);
    checkOutput("nominal_sync_err", 32'(sync_err_o), 0);

    $display("[TB] late arm");
    applyStimulus(3 * LINE_TICKS + 6);
    startPulse();
    base = wrAddrLog.size();
    applyStimulus(FRAME_TICKS - (3 * LINE_TICKS + 6));
    checkOutput("latearm_no_write", 32'(wrAddrLog.size() - base), 0);
    checkOutput("latearm_busy", 32'(busy_o), 1);
    base = wrAddrLog.size();
    d0   = doneCount;
    applyStimulus(FRAME_TICKS);
    checkOutput("latearm_count", 32'(wrAddrLog.size() - base), 32);
    checkFrame("latearm", base);
    checkOutput("latearm_done", 32'(doneCount - d0), 1);
    checkOutput("latearm_busy_after", 32'(busy_o), 0);

    $display("[TB] short line");
    startPulse();
    cutLine = 3;
    base = wrAddrLog.size();
    d0   = doneCount;
    runToFrameStart();
    checkOutput("short_count", 32'(wrAddrLog.size() - base), 13);
    checkOutput("short_no_done", 32'(doneCount - d0), 0);
    checkOutput("short_sync_err", 32'(sync_err_o), 1);
    checkOutput("short_busy", 32'(busy_o), 1);
    base = wrAddrLog.size();
    d0   = doneCount;
    applyStimulus(FRAME_TICKS);
    checkOutput("recover_count", 32'(wrAddrLog.size() - base), 32);
    checkFrame("recover", base);
    checkOutput("recover_done", 32'(doneCount - d0), 1);
    checkOutput("recover_sync_err_sticky", 32'(sync_err_o), 1);
    checkOutput("recover_busy_after", 32'(busy_o), 0);
    startPulse();
    checkOutput("restart_sync_err_clear", 32'(sync_err_o), 0);
    checkOutput("restart_busy", 32'(busy_o), 1);

    $display("[TB] reset mid-capture");
    base  = wrAddrLog.size();
    guard = 0;
    while (wrAddrLog.size() - base < 11 && guard < 200) begin
      applyStimulus(1);
      guard++;
    end
    checkOutput("rst_writes_before", 32'(wrAddrLog.size() - base), 11);
    @(posedge clk_i); #1;
    rstn_i = 1'b0;
    @(posedge clk_i); #1;
    rstn_i = 1'b1;
    checkAllZero("rst_mid");
    runToFrameStart();
    base = wrAddrLog.size();
    d0   = doneCount;
    applyStimulus(FRAME_TICKS);
    checkOutput("rst_idle_no_write", 32'(wrAddrLog.size() - base), 0);
    checkOutput("rst_idle_no_done", 32'(doneCount - d0), 0);
    checkOutput("rst_idle_busy", 32'(busy_o), 0);

    $display("[TB] no strobe");
    startPulse();
    base = wrAddrLog.size();
    d0   = doneCount;
    applyStimulus(3 * LINE_TICKS + 6);
    checkOutput("nostrobe_before", 32'(wrAddrLog.size() - base), 10);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk_i); #1;
      vga_hs_i  = i[0];
      vga_vs_i  = i[1];
      vga_rgb_i = 12'($urandom);
    end
    @(posedge clk_i); #1;
    vga_hs_i = 1'b1;
    vga_vs_i = 1'b1;
    checkOutput("nostrobe_during", 32'(wrAddrLog.size() - base), 10);
    checkOutput("nostrobe_busy", 32'(busy_o), 1);
    runToFrameStart();
    checkOutput("nostrobe_count", 32'(wrAddrLog.size() - base), 32);
    checkFrame("nostrobe", base);
    checkOutput("nostrobe_done", 32'(doneCount - d0), 1);
    checkOutput("nostrobe_sync_err", 32'(sync_err_o), 0);

    $display("[TB] back-to-back");
    startPulse();
    armAfterDone = 1'b1;
    base = wrAddrLog.size();
    d0   = doneCount;
    applyStimulus(FRAME_TICKS);
    applyStimulus(FRAME_TICKS);
    checkOutput("b2b_count", 32'(wrAddrLog.size() - base), 64);
    checkFrame("b2b_first", base);
    checkFrame("b2b_second", base + 32);
    checkOutput("b2b_done", 32'(doneCount - d0), 2);
    checkOutput("b2b_busy_after", 32'(busy_o), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule

// File: doc/vga_capture.md
VGA_CAPTURE -- requirements
Module: vga_capture

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- H_ACTIVE, 640, visible pixels per line
- H_SYNC, 96, HS pulse width in pixel ticks
- H_BP, 48, horizontal back porch in pixel ticks
- V_ACTIVE, 480, visible lines per frame
- V_SYNC, 2, VS pulse width in lines
- V_BP, 33, vertical back porch in lines
- AW, 19, write-address width; 2^AW SHALL be at least H_ACTIVE*V_ACTIVE
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk_i, in, 1, single system clock; all logic on its rising edge
- rstn_i, in, 1, reset; synchronous, active-low
- pix_ce_i, in, 1, pixel tick strobe; one clk-wide pulse per pixel
- start_i, in, 1, arm a single-frame capture
- vga_rgb_i, in, 12, pixel data {R[3:0],G[3:0],B[3:0]}
- vga_hs_i, in, 1, horizontal sync, active-low
- vga_vs_i, in, 1, vertical sync, active-low
- wr_en_o, out, 1, framebuffer write strobe
- wr_addr_o, out, AW, framebuffer write address
- wr_data_o, out, 12, framebuffer write data
- busy_o, out, 1, high while armed or capturing
- capture_done_o, out, 1, one-clk pulse when a frame completes
- sync_err_o, out, 1, sticky sync-timing error flag

Function
REQ-003 Sampling SHALL occur only on cycles with pix_ce_i=1; all other cycles hold state, and wr_en_o=0.
REQ-004 HS and VS falling edges SHALL be detected against the values registered on the previous pix_ce_i tick.
REQ-005 h_cnt SHALL load 0 on the HS-falling tick, else increment by 1 per tick, saturating at all-ones.
REQ-006 v_cnt SHALL load 0 on the VS-falling tick, else increment by 1 on each HS-falling tick.
REQ-007 A tick SHALL be active when H_SYNC+H_BP <= h_cnt < H_SYNC+H_BP+H_ACTIVE and V_SYNC+V_BP <= v_cnt < V_SYNC+V_BP+V_ACTIVE.
REQ-008 FSM states SHALL be IDLE, WAIT_VS, CAPTURE and DONE.
REQ-009 IDLE -> WAIT_VS when start_i=1; start_i SHALL be ignored in all other states.
REQ-010 WAIT_VS -> CAPTURE on the first VS-falling tick; a capture in progress when start_i is asserted SHALL never be joined mid-frame.
REQ-011 In CAPTURE, each active tick SHALL drive the following one clk after the tick (latency 1):
- wr_en_o=1
- wr_data_o = vga_rgb_i sampled on that tick
- wr_addr_o = current pixel index, starting at 0 and incrementing by 1 after each write (raster order, no gaps)
REQ-012 When the write with address H_ACTIVE*V_ACTIVE-1 issues, the FSM SHALL go to DONE; DONE SHALL pulse capture_done_o for exactly one clk, then return to IDLE.
REQ-013 busy_o SHALL equal 1 in WAIT_VS and CAPTURE, else 0.
REQ-014 In CAPTURE, a sync error SHALL be any of:
- an HS-falling tick with H_SYNC+H_BP <= h_cnt < H_SYNC+H_BP+H_ACTIVE (line cut short)
- a VS-falling tick before the final write
On a sync error: sync_err_o SHALL set, the pixel index SHALL reset to 0, and the FSM SHALL go to WAIT_VS without asserting capture_done_o. The VS-falling tick that caused the error SHALL NOT itself start a new capture.
REQ-015 sync_err_o SHALL clear only on reset or on an accepted start_i.
REQ-016 Simultaneous HS-falling and VS-falling on one tick: both counters SHALL load 0, so v_cnt=0.

Reset
REQ-017 While rstn_i=0 at a clk edge, the block SHALL apply the following, which SHALL hold for any state, including mid-capture with no partial completion pulse:
- FSM=IDLE
- h_cnt=0, v_cnt=0, pixel index=0
- registered HS/VS = 1
- wr_en_o=0, wr_addr_o=0, wr_data_o=0
- busy_o=0, capture_done_o=0, sync_err_o=0

Verification
REQ-018 Benches SHALL use H_ACTIVE=8, H_SYNC=2, H_BP=2, V_ACTIVE=4, V_SYNC=1, V_BP=1, with pix_ce_i every 4th clk and a fixed front porch of 2 ticks / 1 line from a model source.
REQ-019 The following scenarios SHALL be covered:
- Nominal: pix_ce_i every 4th clk, start_i pulse, source frame with pixel value = index. Required: 32 writes, addr 0..31, data 0x000..0x01F, capture_done_o once, busy_o low after.
- Late arm: start_i asserted mid-frame. Required: no write until the next VS falling edge, then a full 32-write frame.
- Short line: one line's HS falls at pixel 5. Required: sync_err_o=1, no capture_done_o, the next clean frame captures correctly, and sync_err_o stays 1 until the next start_i.
- Reset mid-capture: rstn_i=0 for one clk after write 10. Required: all outputs 0 the next cycle, FSM in IDLE, and a subsequent VS edge produces no writes without start_i.
- No strobe: pix_ce_i held 0 while the sync inputs toggle. Required: no writes, counters unchanged.
- Back-to-back: a second start_i one clk after capture_done_o. Required: the second frame captures with addresses restarting at 0.
